eco32_core_ifu_icu_way_mem_mt: RTL and testbench

- Next-generation storage array for one instruction-cache way in the IFU.
- Generalised in thread count, line length and data width.
- Adds a built-in line-refill sequencer that writes a whole line critical-word-first under a valid/ready handshake.
- Adds write-to-read bypass on address collision and an optional output pipeline register.
- Sits between the ICU way tag logic (read side) and the fetch miss/refill path (fill side).

---
 rtl/eco32_core_ifu_pkg.sv | 16 +
 rtl/eco32_core_ifu_icu_way_mem_mt_if.sv | 38 +++
 rtl/eco32_core_ifu_icu_fill_seq.sv | 110 +++++++++++
 rtl/eco32_core_ifu_icu_way_mem_mt.sv | 108 ++++++++++
 tb/tb_eco32_core_ifu_icu_way_mem_mt.sv | 383 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/eco32_core_ifu_pkg.sv
// Shared IFU definitions: fill sequencer state encoding and array address sizing.
package eco32_core_ifu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_DONE = 2'd2
  } fill_state_e;

  function automatic int unsigned addr_width(input int unsigned page_w,
                                             input int unsigned tid_w,
                                             input int unsigned off_w);
    return page_w + tid_w + off_w;
  endfunction

endpackage

// File: rtl/eco32_core_ifu_icu_way_mem_mt_if.sv
// Read port and line-refill port of one I-cache way data array.
interface eco32_core_ifu_icu_way_mem_mt_if #(
  parameter int unsigned PAGE_ADDR_WIDTH = 5,
  parameter int unsigned TID_WIDTH       = 1,
  parameter int unsigned OFFSET_WIDTH    = 3,
  parameter int unsigned DATA_WIDTH      = 72
);
  logic                       i_stb;
  logic [TID_WIDTH-1:0]       i_tid;
  logic [PAGE_ADDR_WIDTH-1:0] i_page;
  logic [OFFSET_WIDTH-1:0]    i_offset;
  logic                       o_stb;
  logic [DATA_WIDTH-1:0]      o_data;
  logic                       o_byp;

  logic                       fill_req;
  logic [TID_WIDTH-1:0]       fill_tid;
  logic [PAGE_ADDR_WIDTH-1:0] fill_page;
  logic [OFFSET_WIDTH-1:0]    fill_offset;
  logic                       fill_abort;
  logic                       fill_dval;
  logic [DATA_WIDTH-1:0]      fill_data;
  logic                       fill_rdy;
  logic                       fill_busy;
  logic                       fill_done;

  modport master (
    output i_stb, i_tid, i_page, i_offset,
    output fill_req, fill_tid, fill_page, fill_offset, fill_abort, fill_dval, fill_data,
    input  o_stb, o_data, o_byp, fill_rdy, fill_busy, fill_done
  );

  modport slave (
    input  i_stb, i_tid, i_page, i_offset,
    input  fill_req, fill_tid, fill_page, fill_offset, fill_abort, fill_dval, fill_data,
    output o_stb, o_data, o_byp, fill_rdy, fill_busy, fill_done
  );
endinterface

// File: rtl/eco32_core_ifu_icu_fill_seq.sv
// Line-refill sequencer: writes one full line critical-word-first, wrapping the
// word offset, under a dval/rdy handshake with abort.
module eco32_core_ifu_icu_fill_seq
  import eco32_core_ifu_pkg::*;
#(
  parameter int unsigned PAGE_ADDR_WIDTH = 5,
  parameter int unsigned TID_WIDTH       = 1,
  parameter int unsigned OFFSET_WIDTH    = 3,
  parameter int unsigned DATA_WIDTH      = 72,
  localparam int unsigned AW = addr_width(PAGE_ADDR_WIDTH, TID_WIDTH, OFFSET_WIDTH)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       fill_req_i,
  input  logic [TID_WIDTH-1:0]       fill_tid_i,
  input  logic [PAGE_ADDR_WIDTH-1:0] fill_page_i,
  input  logic [OFFSET_WIDTH-1:0]    fill_offset_i,
  input  logic                       fill_abort_i,
  input  logic                       fill_dval_i,
  input  logic [DATA_WIDTH-1:0]      fill_data_i,
  output logic                       fill_rdy_o,
  output logic                       fill_busy_o,
  output logic                       fill_done_o,
  output logic                       wr_ena_c_o,
  output logic [AW-1:0]              wr_addr_c_o,
  output logic [DATA_WIDTH-1:0]      wr_data_c_o
);

  localparam int unsigned CW        = OFFSET_WIDTH + 1;
  localparam int unsigned LINE_LAST = (1 << OFFSET_WIDTH) - 1;

  fill_state_e                state_q, state_d;
  logic [TID_WIDTH-1:0]       tid_q, tid_d;
  logic [PAGE_ADDR_WIDTH-1:0] page_q, page_d;
  logic [OFFSET_WIDTH-1:0]    off_q, off_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic                       rdy_q, rdy_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;

  // State, latched line address, counters and registered status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      tid_q   <= '0;
      page_q  <= '0;
      off_q   <= '0;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tid_q   <= tid_d;
      page_q  <= page_d;
      off_q   <= off_d;
      cnt_q   <= cnt_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next state; abort wins over a word offered in the same cycle.
  always_comb begin
    state_d = state_q;
    tid_d   = tid_q;
    page_d  = page_q;
    off_d   = off_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (fill_req_i) begin
          state_d = S_FILL;
          tid_d   = fill_tid_i;
          page_d  = fill_page_i;
          off_d   = fill_offset_i;
          cnt_d   = '0;
        end
      end
      S_FILL: begin
        if (fill_abort_i) begin
          state_d = S_IDLE;
        end else if (fill_dval_i) begin
          off_d = off_q + OFFSET_WIDTH'(1);
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(LINE_LAST)) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Array write strobe plus status flags derived from the upcoming state.
  always_comb begin
    wr_ena_c_o  = 1'b0;
    wr_addr_c_o = {page_q, tid_q, off_q};
    wr_data_c_o = fill_data_i;
    rdy_d       = (state_d == S_FILL);
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    if (state_q == S_FILL && fill_dval_i && !fill_abort_i) wr_ena_c_o = 1'b1;
  end

  assign fill_rdy_o  = rdy_q;
  assign fill_busy_o = busy_q;
  assign fill_done_o = done_q;

endmodule

// File: rtl/eco32_core_ifu_icu_way_mem_mt.sv
// Data array for one I-cache way: multi-thread partitions, refill sequencer,
// write-to-read bypass and optional second output stage.
module eco32_core_ifu_icu_way_mem_mt
  import eco32_core_ifu_pkg::*;
#(
  parameter int unsigned PAGE_ADDR_WIDTH = 5,
  parameter int unsigned TID_WIDTH       = 1,
  parameter int unsigned OFFSET_WIDTH    = 3,
  parameter int unsigned DATA_WIDTH      = 72,
  parameter int unsigned OUT_REG         = 0
) (
  input logic clk,
  input logic rst_n,
  eco32_core_ifu_icu_way_mem_mt_if.slave bus
);

  localparam int unsigned AW    = addr_width(PAGE_ADDR_WIDTH, TID_WIDTH, OFFSET_WIDTH);
  localparam int unsigned DEPTH = 1 << AW;

  logic                  wr_ena_c;
  logic [AW-1:0]         wr_addr_c;
  logic [DATA_WIDTH-1:0] wr_data_c;
  logic [AW-1:0]         rd_addr_c;
  logic                  byp_hit_c;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  s1_stb_q, s1_stb_d;
  logic                  s1_byp_q, s1_byp_d;
  logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d;

  eco32_core_ifu_icu_fill_seq #(
    .PAGE_ADDR_WIDTH (PAGE_ADDR_WIDTH),
    .TID_WIDTH       (TID_WIDTH),
    .OFFSET_WIDTH    (OFFSET_WIDTH),
    .DATA_WIDTH      (DATA_WIDTH)
  ) u_fill_seq (
    .clk           (clk),
    .rst_n         (rst_n),
    .fill_req_i    (bus.fill_req),
    .fill_tid_i    (bus.fill_tid),
    .fill_page_i   (bus.fill_page),
    .fill_offset_i (bus.fill_offset),
    .fill_abort_i  (bus.fill_abort),
    .fill_dval_i   (bus.fill_dval),
    .fill_data_i   (bus.fill_data),
    .fill_rdy_o    (bus.fill_rdy),
    .fill_busy_o   (bus.fill_busy),
    .fill_done_o   (bus.fill_done),
    .wr_ena_c_o    (wr_ena_c),
    .wr_addr_c_o   (wr_addr_c),
    .wr_data_c_o   (wr_data_c)
  );

  // Storage array; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_ena_c) mem_q[wr_addr_c] <= wr_data_c;
  end

  assign rd_addr_c = {bus.i_page, bus.i_tid, bus.i_offset};
  assign byp_hit_c = bus.i_stb && wr_ena_c && (wr_addr_c == rd_addr_c);

  // A same-cycle write to the read address must win over the old array word.
  always_comb begin
    s1_stb_d  = bus.i_stb;
    s1_byp_d  = byp_hit_c;
    s1_data_d = '0;
    if (bus.i_stb) s1_data_d = byp_hit_c ? wr_data_c : mem_q[rd_addr_c];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_stb_q  <= 1'b0;
      s1_byp_q  <= 1'b0;
      s1_data_q <= '0;
    end else begin
      s1_stb_q  <= s1_stb_d;
      s1_byp_q  <= s1_byp_d;
      s1_data_q <= s1_data_d;
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic                  s2_stb_q;
    logic                  s2_byp_q;
    logic [DATA_WIDTH-1:0] s2_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s2_stb_q  <= 1'b0;
        s2_byp_q  <= 1'b0;
        s2_data_q <= '0;
      end else begin
        s2_stb_q  <= s1_stb_q;
        s2_byp_q  <= s1_byp_q;
        s2_data_q <= s1_data_q;
      end
    end

    assign bus.o_stb  = s2_stb_q;
    assign bus.o_byp  = s2_byp_q;
    assign bus.o_data = s2_data_q;
  end else begin : g_no_out_reg
    assign bus.o_stb  = s1_stb_q;
    assign bus.o_byp  = s1_byp_q;
    assign bus.o_data = s1_data_q;
  end

endmodule

// File: tb/tb_eco32_core_ifu_icu_way_mem_mt.sv
// Bench for the I-cache way data array: latency-1 and latency-2 instances
// driven in lockstep and compared against a word-level line-refill model.
module tb_eco32_core_ifu_icu_way_mem_mt;

  localparam int unsigned PW = 5;
  localparam int unsigned TW = 1;
  localparam int unsigned OW = 3;
  localparam int unsigned DW = 72;
  localparam int unsigned LINE = 1 << OW;

  logic clk = 1'b0;
  logic rst_n;

  logic          r_stb;
  logic [TW-1:0] r_tid;
  logic [PW-1:0] r_page;
  logic [OW-1:0] r_off;
  logic          r_freq;
  logic [TW-1:0] r_ftid;
  logic [PW-1:0] r_fpage;
  logic [OW-1:0] r_foff;
  logic          r_abort;
  logic          r_dval;
  logic [DW-1:0] r_fdata;

  eco32_core_ifu_icu_way_mem_mt_if #(.PAGE_ADDR_WIDTH(PW), .TID_WIDTH(TW), .OFFSET_WIDTH(OW), .DATA_WIDTH(DW)) if0 ();
  eco32_core_ifu_icu_way_mem_mt_if #(.PAGE_ADDR_WIDTH(PW), .TID_WIDTH(TW), .OFFSET_WIDTH(OW), .DATA_WIDTH(DW)) if1 ();

  assign if0.i_stb = r_stb;     assign if1.i_stb = r_stb;
  assign if0.i_tid = r_tid;     assign if1.i_tid = r_tid;
  assign if0.i_page = r_page;   assign if1.i_page = r_page;
  assign if0.i_offset = r_off;  assign if1.i_offset = r_off;
  assign if0.fill_req = r_freq; assign if1.fill_req = r_freq;
  assign if0.fill_tid = r_ftid; assign if1.fill_tid = r_ftid;
  assign if0.fill_page = r_fpage;  assign if1.fill_page = r_fpage;
  assign if0.fill_offset = r_foff; assign if1.fill_offset = r_foff;
  assign if0.fill_abort = r_abort; assign if1.fill_abort = r_abort;
  assign if0.fill_dval = r_dval;   assign if1.fill_dval = r_dval;
  assign if0.fill_data = r_fdata;  assign if1.fill_data = r_fdata;

  eco32_core_ifu_icu_way_mem_mt #(.PAGE_ADDR_WIDTH(PW), .TID_WIDTH(TW), .OFFSET_WIDTH(OW),
                                  .DATA_WIDTH(DW), .OUT_REG(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  eco32_core_ifu_icu_way_mem_mt #(.PAGE_ADDR_WIDTH(PW), .TID_WIDTH(TW), .OFFSET_WIDTH(OW),
                                  .DATA_WIDTH(DW), .OUT_REG(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  always #5 clk = ~clk;

  // Reference: array image, the line being refilled, and expected read pipeline.
  logic [DW-1:0] ref_mem [1 << (PW + TW + OW)];
  bit            m_filling, m_done;
  logic [TW-1:0] m_tid;
  logic [PW-1:0] m_page;
  logic [OW-1:0] m_off;
  int            m_cnt;
  logic          e1_stb, e1_byp, e2_stb, e2_byp;
  logic [DW-1:0] e1_data, e2_data;
  int            n_checks, n_errors;

  function automatic logic [DW-1:0] rnd72();
    return {8'($urandom), $urandom, $urandom};
  endfunction

  task automatic clear_pipe();
    e1_stb = 1'b0; e1_byp = 1'b0; e1_data = '0;
    e2_stb = 1'b0; e2_byp = 1'b0; e2_data = '0;
  endtask

  task automatic idle_inputs();
    r_stb = 1'b0; r_tid = '0; r_page = '0; r_off = '0;
    r_freq = 1'b0; r_ftid = '0; r_fpage = '0; r_foff = '0;
    r_abort = 1'b0; r_dval = 1'b0; r_fdata = '0;
  endtask

  // Advance one clock: predict from the inputs now applied, then compare both instances.
  task automatic step();
    logic          wr, n_byp;
    logic [DW-1:0] n_data;
    int            wa, ra;
    wr     = m_filling && r_dval && !r_abort;
    wa     = int'({m_page, m_tid, m_off});
    ra     = int'({r_page, r_tid, r_off});
    n_byp  = r_stb && wr && (wa == ra);
    n_data = !r_stb ? '0 : (n_byp ? r_fdata : ref_mem[ra]);
    if (m_done) begin
      m_done = 1'b0;
    end else if (m_filling) begin
      if (r_abort) begin
        m_filling = 1'b0;
      end else if (r_dval) begin
        ref_mem[wa] = r_fdata;
        m_off = m_off + OW'(1);
        m_cnt++;
        if (m_cnt == int'(LINE)) begin
          m_filling = 1'b0;
          m_done = 1'b1;
        end
      end
    end else if (r_freq) begin
      m_filling = 1'b1;
      m_tid = r_ftid; m_page = r_fpage; m_off = r_foff; m_cnt = 0;
    end
    e2_stb = e1_stb; e2_byp = e1_byp; e2_data = e1_data;
    e1_stb = r_stb;  e1_byp = n_byp;  e1_data = n_data;
    @(posedge clk); #1;
    n_checks++;
    if (if0.o_stb !== e1_stb || if0.o_byp !== e1_byp || if0.o_data !== e1_data) begin
      n_errors++;
      $display("FAIL read_lat1 @%0t: stb=%b byp=%b data=%h, expected stb=%b byp=%b data=%h",
               $time, if0.o_stb, if0.o_byp, if0.o_data, e1_stb, e1_byp, e1_data);
    end
    n_checks++;
    if (if1.o_stb !== e2_stb || if1.o_byp !== e2_byp || if1.o_data !== e2_data) begin
      n_errors++;
      $display("FAIL read_lat2 @%0t: stb=%b byp=%b data=%h, expected stb=%b byp=%b data=%h",
               $time, if1.o_stb, if1.o_byp, if1.o_data, e2_stb, e2_byp, e2_data);
    end
    n_checks++;
    if ({if0.fill_rdy, if0.fill_busy, if0.fill_done} !== {m_filling, m_filling | m_done, m_done} ||
        {if1.fill_rdy, if1.fill_busy, if1.fill_done} !== {m_filling, m_filling | m_done, m_done}) begin
      n_errors++;
      $display("FAIL fill_status @%0t: rdy/busy/done=%b%b%b|%b%b%b, expected %b%b%b", $time,
               if0.fill_rdy, if0.fill_busy, if0.fill_done, if1.fill_rdy, if1.fill_busy, if1.fill_done,
               m_filling, m_filling | m_done, m_done);
    end
  endtask

  // Random read, half the time aimed at the word the refill writes next.
  task automatic rand_read();
    r_stb = 1'($urandom_range(0, 1));
    if (m_filling && $urandom_range(0, 1) == 1) begin
      r_page = m_page; r_tid = m_tid; r_off = m_off;
    end else begin
      r_page = PW'($urandom); r_tid = TW'($urandom); r_off = OW'($urandom);
    end
  endtask

  task automatic do_fill(input logic [TW-1:0] tid, input logic [PW-1:0] page,
                         input logic [OW-1:0] off, input bit gaps, output int pulses);
    int cyc;
    pulses = 0;
    r_freq = 1'b1; r_ftid = tid; r_fpage = page; r_foff = off;
    r_dval = 1'b0; r_abort = 1'b0;
    rand_read();
    step();
    r_freq = 1'b0;
    cyc = 0;
    while ((m_filling || m_done) && cyc < 64) begin
      r_dval  = gaps ? (cyc % 3 == 0) : 1'b1;
      r_fdata = rnd72();
      rand_read();
      step();
      if (if0.fill_done === 1'b1) pulses++;
      cyc++;
    end
    r_dval = 1'b0; r_stb = 1'b0;
  endtask

  task automatic read_line(input logic [TW-1:0] tid, input logic [PW-1:0] page);
    for (int o = 0; o < int'(LINE); o++) begin
      r_stb = 1'b1; r_tid = tid; r_page = page; r_off = OW'(o);
      step();
    end
    r_stb = 1'b0;
    step();
    step();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    m_filling = 1'b0; m_done = 1'b0; m_cnt = 0;
    m_tid = '0; m_page = '0; m_off = '0;
    clear_pipe();
    #3;
    n_checks++;
    if ({if0.o_stb, if0.o_byp, if0.fill_rdy, if0.fill_busy, if0.fill_done} !== 5'b0 || if0.o_data !== '0) begin
      n_errors++;
      $display("FAIL reset_lat1: stb/byp/rdy/busy/done=%b%b%b%b%b data=%h, expected all 0",
               if0.o_stb, if0.o_byp, if0.fill_rdy, if0.fill_busy, if0.fill_done, if0.o_data);
    end
    n_checks++;
    if ({if1.o_stb, if1.o_byp, if1.fill_rdy, if1.fill_busy, if1.fill_done} !== 5'b0 || if1.o_data !== '0) begin
      n_errors++;
      $display("FAIL reset_lat2: stb/byp/rdy/busy/done=%b%b%b%b%b data=%h, expected all 0",
               if1.o_stb, if1.o_byp, if1.fill_rdy, if1.fill_busy, if1.fill_done, if1.o_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) step();
  endtask

  // Linear fills of every line so later reads always have a known reference.
  task automatic test_preload();
    int p;
    for (int pg = 0; pg < (1 << PW); pg++)
      for (int t = 0; t < (1 << TW); t++)
        do_fill(TW'(t), PW'(pg), '0, 1'b0, p);
  endtask

  task automatic test_critical_word();
    logic [DW-1:0] d [LINE];
    for (int i = 0; i < int'(LINE); i++) d[i] = rnd72();
    r_freq = 1'b1; r_ftid = 1'b1; r_fpage = 5'h0A; r_foff = 3'd6;
    step();
    r_freq = 1'b0;
    for (int i = 0; i < int'(LINE); i++) begin
      r_dval = 1'b1; r_fdata = d[i];
      step();
    end
    r_dval = 1'b0;
    n_checks++;
    if (if0.fill_done !== 1'b1 || if0.fill_busy !== 1'b1) begin
      n_errors++;
      $display("FAIL crit_done_pulse: done=%b busy=%b, expected 1 1", if0.fill_done, if0.fill_busy);
    end
    r_freq = 1'b1; r_fpage = 5'h03;
    step();
    r_freq = 1'b0;
    n_checks++;
    if (if0.fill_busy !== 1'b0 || if0.fill_done !== 1'b0) begin
      n_errors++;
      $display("FAIL req_in_done_ignored: busy=%b done=%b, expected 0 0", if0.fill_busy, if0.fill_done);
    end
    for (int o = 0; o < int'(LINE); o++) begin
      r_stb = 1'b1; r_tid = 1'b1; r_page = 5'h0A; r_off = OW'(o);
      step();
      r_stb = 1'b0;
      n_checks++;
      if (if0.o_data !== d[(o + 2) % LINE]) begin
        n_errors++;
        $display("FAIL crit_order_lat1 off=%0d: data=%h, expected %h", o, if0.o_data, d[(o + 2) % LINE]);
      end
      step();
      n_checks++;
      if (if1.o_data !== d[(o + 2) % LINE]) begin
        n_errors++;
        $display("FAIL crit_order_lat2 off=%0d: data=%h, expected %h", o, if1.o_data, d[(o + 2) % LINE]);
      end
    end
  endtask

  task automatic test_bypass();
    r_freq = 1'b1; r_ftid = 1'b1; r_fpage = 5'h0A; r_foff = 3'd7;
    step();
    r_freq = 1'b0;
    r_dval = 1'b1; r_fdata = 72'hABC;
    r_stb = 1'b1; r_tid = 1'b1; r_page = 5'h0A; r_off = 3'd7;
    step();
    n_checks++;
    if (if0.o_data !== 72'hABC || if0.o_byp !== 1'b1) begin
      n_errors++;
      $display("FAIL bypass_lat1: data=%h byp=%b, expected abc 1", if0.o_data, if0.o_byp);
    end
    r_stb = 1'b0; r_fdata = rnd72();
    step();
    n_checks++;
    if (if1.o_data !== 72'hABC || if1.o_byp !== 1'b1) begin
      n_errors++;
      $display("FAIL bypass_lat2: data=%h byp=%b, expected abc 1", if1.o_data, if1.o_byp);
    end
    while (m_filling || m_done) begin
      r_dval = 1'b1; r_fdata = rnd72();
      rand_read();
      step();
    end
    r_dval = 1'b0; r_stb = 1'b0;
    read_line(1'b1, 5'h0A);
  endtask

  task automatic test_gaps();
    int pulses;
    logic [TW-1:0] t;
    logic [PW-1:0] pg;
    for (int k = 0; k < 3; k++) begin
      t = TW'($urandom); pg = PW'($urandom);
      do_fill(t, pg, OW'($urandom), 1'b1, pulses);
      n_checks++;
      if (pulses != 1) begin
        n_errors++;
        $display("FAIL gap_done_pulses: pulses=%0d, expected 1", pulses);
      end
      read_line(t, pg);
    end
  endtask

  task automatic test_idle_noise();
    for (int i = 0; i < 24; i++) begin
      r_dval = 1'b1; r_fdata = rnd72(); r_abort = 1'($urandom_range(0, 1));
      rand_read();
      step();
    end
    r_dval = 1'b0; r_abort = 1'b0; r_stb = 1'b0;
    read_line('0, '0);
  endtask

  task automatic test_abort();
    r_freq = 1'b1; r_abort = 1'b1; r_ftid = 1'b0; r_fpage = 5'h11; r_foff = 3'd5;
    step();
    r_freq = 1'b0; r_abort = 1'b0;
    n_checks++;
    if (if0.fill_busy !== 1'b1) begin
      n_errors++;
      $display("FAIL abort_in_idle: busy=%b, expected 1", if0.fill_busy);
    end
    for (int w = 0; w < 4; w++) begin
      r_dval = 1'b1; r_fdata = rnd72(); r_abort = (w == 3);
      step();
    end
    r_dval = 1'b0; r_abort = 1'b0;
    n_checks++;
    if ({if0.fill_rdy, if0.fill_busy, if0.fill_done} !== 3'b000) begin
      n_errors++;
      $display("FAIL abort_to_idle: rdy/busy/done=%b%b%b, expected 000",
               if0.fill_rdy, if0.fill_busy, if0.fill_done);
    end
    r_freq = 1'b1; r_ftid = 1'b1; r_fpage = 5'h12; r_foff = 3'd0;
    step();
    r_freq = 1'b0;
    n_checks++;
    if (if0.fill_busy !== 1'b1 || if0.fill_rdy !== 1'b1) begin
      n_errors++;
      $display("FAIL req_after_abort: busy=%b rdy=%b, expected 1 1", if0.fill_busy, if0.fill_rdy);
    end
    while (m_filling || m_done) begin
      r_dval = 1'b1; r_fdata = rnd72();
      step();
    end
    r_dval = 1'b0;
    read_line(1'b0, 5'h11);
    read_line(1'b1, 5'h12);
  endtask

  task automatic test_reset_mid_fill();
    r_freq = 1'b1; r_ftid = 1'b1; r_fpage = 5'h07; r_foff = 3'd3;
    step();
    r_freq = 1'b0;
    for (int w = 0; w < 2; w++) begin
      r_dval = 1'b1; r_fdata = rnd72();
      r_stb = 1'b1; r_tid = 1'b0; r_page = PW'($urandom); r_off = OW'($urandom);
      step();
    end
    idle_inputs();
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({if0.o_stb, if0.o_byp, if0.fill_rdy, if0.fill_busy, if0.fill_done} !== 5'b0 || if0.o_data !== '0 ||
        {if1.o_stb, if1.o_byp, if1.fill_rdy, if1.fill_busy, if1.fill_done} !== 5'b0 || if1.o_data !== '0) begin
      n_errors++;
      $display("FAIL async_reset_mid_fill: lat1 %b%b%b%b%b %h lat2 %b%b%b%b%b %h, expected all 0",
               if0.o_stb, if0.o_byp, if0.fill_rdy, if0.fill_busy, if0.fill_done, if0.o_data,
               if1.o_stb, if1.o_byp, if1.fill_rdy, if1.fill_busy, if1.fill_done, if1.o_data);
    end
    m_filling = 1'b0; m_done = 1'b0;
    clear_pipe();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    read_line(1'b1, 5'h07);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    test_reset();
    test_preload();
    test_critical_word();
    test_bypass();
    test_gaps();
    test_idle_noise();
    test_abort();
    test_reset_mid_fill();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
